// File: rtl/control_pkg.sv
// Shared encodings, FSM state and instruction decode for the control unit.
// The decode table is pure combinational; the top adds condition gating and memory sequencing.
package control_pkg;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_NOP = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;

  typedef enum logic {S_EXEC, S_WAIT} state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic [1:0] alu_ctl;
    logic       alu_src;
    logic       mem_to_reg;
    logic       dp_write;   // command writes Rd
    logic       dp_valid;   // recognised data-processing command (may set NZ)
    logic       cv_update;  // arithmetic command, also sets CV
    logic       is_load;
    logic       is_store;
    logic       branch;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] op, input logic [5:0] funct);
    dec_t d;
    d = '0;
    d.alu_ctl = ALU_ADD;
    case (op)
      OP_DP: begin
        d.alu_src = funct[5];
        case (funct[4:1])
          CMD_ADD: begin d.alu_ctl = ALU_ADD; d.dp_write = 1'b1; d.dp_valid = 1'b1; d.cv_update = 1'b1; end
          CMD_SUB: begin d.alu_ctl = ALU_SUB; d.dp_write = 1'b1; d.dp_valid = 1'b1; d.cv_update = 1'b1; end
          CMD_AND: begin d.alu_ctl = ALU_AND; d.dp_write = 1'b1; d.dp_valid = 1'b1; end
          CMD_ORR: begin d.alu_ctl = ALU_ORR; d.dp_write = 1'b1; d.dp_valid = 1'b1; end
          CMD_CMP: begin d.alu_ctl = ALU_SUB; d.dp_valid = 1'b1; d.cv_update = 1'b1; end
          default: ;
        endcase
      end
      OP_MEM: begin
        d.alu_src = 1'b1;
        d.imm_src = 2'b01;
        d.alu_ctl = funct[3] ? ALU_ADD : ALU_SUB;
        if (funct[0]) begin
          d.is_load    = 1'b1;
          d.mem_to_reg = 1'b1;
        end else begin
          d.is_store = 1'b1;
          d.reg_src  = 2'b10;
        end
      end
      OP_BR: begin
        d.imm_src = 2'b10;
        d.alu_src = 1'b1;
        d.reg_src = 2'b01;
        d.branch  = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Data-memory handshake: the controller requests, memory signals completion with MemReady.
interface control_unit_if;
  logic MemReq;
  logic MemWrite;
  logic MemReady;

  modport master (output MemReq, output MemWrite, input MemReady);
  modport slave  (input MemReq, input MemWrite, output MemReady);
endinterface

// File: rtl/control_unit_cond_logic.sv
// ARM condition-code evaluation against NZCV flags; purely combinational.
module cond_logic
  import control_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;
  assign {n, z, c, v} = Flags;

  always_comb begin
    CondEx = 1'b0;
    case (cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Single-cycle decode plus an EXEC/WAIT sequencer that stalls on slow data memory.
// Decode outputs are same-cycle; Stall holds PC/Instr while MemReady is low, up to MEM_TIMEOUT cycles.
module control_unit
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Instr,
  input  logic [3:0]            ALUFlags,
  control_unit_if.master        mem,
  output logic [1:0]            RegSrc,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            ALUControl,
  output logic                  RegWrite,
  output logic                  ALUSrc,
  output logic                  MemtoReg,
  output logic                  PCSrc,
  output logic                  Stall,
  output logic                  MemErr,
  output logic [3:0]            Flags
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W:0]     cnt_inc;
  flags_t             flags_q;
  logic               mem_err_q;

  dec_t               dec;
  logic               cond_ex;
  logic               is_mem;
  logic               timeout;
  logic               mem_req, mem_write, reg_write, stall, pc_src;
  logic               unused_instr;

  assign dec          = decode(Instr[27:26], Instr[25:20]);
  assign is_mem       = dec.is_load | dec.is_store;
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  cond_logic u_cond (
    .cond   (Instr[31:28]),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  // Abort in the cycle the counter would reach MEM_TIMEOUT, so the EXEC cycle counts as wait 1.
  assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign timeout = (cnt_inc >= (CNT_W + 1)'(MEM_TIMEOUT));

  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    stall     = 1'b0;
    if (reset) begin
      case (state)
        S_EXEC: begin
          if (cond_ex) begin
            reg_write = dec.dp_write;
            if (is_mem) begin
              mem_req   = 1'b1;
              mem_write = dec.is_store;
              if (mem.MemReady) reg_write = dec.is_load;
              else              stall     = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (mem.MemReady) begin
            mem_req   = 1'b1;
            mem_write = dec.is_store;
            reg_write = dec.is_load;
          end else if (!timeout) begin
            mem_req   = 1'b1;
            mem_write = dec.is_store;
            stall     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_src = reset & cond_ex & ~stall &
                  (dec.branch | (reg_write & (Instr[15:12] == 4'hF)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_EXEC;
      cnt       <= '0;
      flags_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        S_EXEC: begin
          if (cond_ex && is_mem && !mem.MemReady) begin
            state <= S_WAIT;
            cnt   <= CNT_W'(1);
          end
          if (cond_ex && dec.dp_valid && Instr[20]) begin
            flags_q.n <= ALUFlags[3];
            flags_q.z <= ALUFlags[2];
            if (dec.cv_update) begin
              flags_q.c <= ALUFlags[1];
              flags_q.v <= ALUFlags[0];
            end
          end
        end
        S_WAIT: begin
          if (mem.MemReady || timeout) begin
            state <= S_EXEC;
            cnt   <= '0;
            if (!mem.MemReady) mem_err_q <= 1'b1;
          end else begin
            cnt <= cnt_inc[CNT_W-1:0];
          end
        end
        default: state <= S_EXEC;
      endcase
    end
  end

  assign mem.MemReq   = mem_req;
  assign mem.MemWrite = mem_write;
  assign RegSrc       = dec.reg_src;
  assign ImmSrc       = dec.imm_src;
  assign ALUControl   = dec.alu_ctl;
  assign ALUSrc       = dec.alu_src;
  assign MemtoReg     = dec.mem_to_reg;
  assign RegWrite     = reg_write;
  assign PCSrc        = pc_src;
  assign Stall        = stall;
  assign MemErr       = mem_err_q;
  assign Flags        = flags_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a cycle-level reference model checked on every falling edge.
module tb_control_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic        RegWrite, ALUSrc, MemtoReg, PCSrc, Stall, MemErr;
  logic [3:0]  Flags;

  control_unit_if mem ();

  control_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .mem        (mem),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .MemtoReg   (MemtoReg),
    .PCSrc      (PCSrc),
    .Stall      (Stall),
    .MemErr     (MemErr),
    .Flags      (Flags)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model state: architectural flags, cycles an access has been pending, sticky error.
  logic [3:0] m_flags = 4'h0;
  int         m_k     = 0;
  logic       m_err   = 1'b0;

  always @(negedge clk) begin : compare
    logic [3:0] cnd, cmd, rd, nf;
    logic [1:0] op;
    logic       i_b, s_b, u_b, l_b, pass, e_rw, e_req, e_mw, e_stall, e_pc, n_err;
    int         nk, e_alu;
    if (!reset) begin
      m_flags = 4'h0; m_k = 0; m_err = 1'b0;
      chk("rst_regwrite", 32'(RegWrite), 0);
      chk("rst_memreq",   32'(mem.MemReq), 0);
      chk("rst_memwrite", 32'(mem.MemWrite), 0);
      chk("rst_pcsrc",    32'(PCSrc), 0);
      chk("rst_stall",    32'(Stall), 0);
      chk("rst_flags",    32'(Flags), 0);
      chk("rst_memerr",   32'(MemErr), 0);
    end else begin
      cnd = Instr[31:28]; op = Instr[27:26]; i_b = Instr[25]; cmd = Instr[24:21];
      s_b = Instr[20]; u_b = Instr[23]; l_b = Instr[20]; rd = Instr[15:12];
      pass = passes(cnd, m_flags);
      e_rw = 0; e_req = 0; e_mw = 0; e_stall = 0;
      nf = m_flags; nk = 0; n_err = m_err;
      if (m_k > 0) begin
        if (mem.MemReady) begin
          e_req = 1; e_mw = !l_b; e_rw = l_b;
        end else if (m_k + 1 >= TO) begin
          n_err = 1;
        end else begin
          e_req = 1; e_mw = !l_b; e_stall = 1; nk = m_k + 1;
        end
      end else if (pass) begin
        if (op == 2'b00) begin
          e_rw = (cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd0 || cmd == 4'd12);
          if (s_b && (e_rw || cmd == 4'd10)) begin
            nf[3:2] = ALUFlags[3:2];
            if (cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd10) nf[1:0] = ALUFlags[1:0];
          end
        end else if (op == 2'b01) begin
          e_req = 1; e_mw = !l_b;
          if (mem.MemReady) e_rw = l_b;
          else begin e_stall = 1; nk = 1; end
        end
      end
      e_pc = pass && !e_stall && (op == 2'b10 || (e_rw && rd == 4'hF));
      chk("m_regwrite", 32'(RegWrite), 32'(e_rw));
      chk("m_memreq",   32'(mem.MemReq), 32'(e_req));
      chk("m_memwrite", 32'(mem.MemWrite), 32'(e_mw));
      chk("m_stall",    32'(Stall), 32'(e_stall));
      chk("m_pcsrc",    32'(PCSrc), 32'(e_pc));
      chk("m_flags",    32'(Flags), 32'(m_flags));
      chk("m_memerr",   32'(MemErr), 32'(m_err));
      if (op == 2'b00) begin
        chk("m_alusrc_dp", 32'(ALUSrc), 32'(i_b));
        chk("m_immsrc_dp", 32'(ImmSrc), 0);
        chk("m_regsrc_dp", 32'(RegSrc), 0);
        case (cmd)
          4'd4: e_alu = 0;
          4'd2, 4'd10: e_alu = 1;
          4'd0: e_alu = 2;
          4'd12: e_alu = 3;
          default: e_alu = -1;
        endcase
        if (e_alu >= 0) chk("m_aluctl_dp", 32'(ALUControl), e_alu);
      end else if (op == 2'b01) begin
        chk("m_alusrc_mem",   32'(ALUSrc), 1);
        chk("m_immsrc_mem",   32'(ImmSrc), 1);
        chk("m_aluctl_mem",   32'(ALUControl), u_b ? 0 : 1);
        chk("m_regsrc_mem",   32'(RegSrc), l_b ? 0 : 2);
        chk("m_memtoreg_mem", 32'(MemtoReg), 32'(l_b));
      end else if (op == 2'b10) begin
        chk("m_alusrc_br", 32'(ALUSrc), 1);
        chk("m_immsrc_br", 32'(ImmSrc), 2);
        chk("m_regsrc_br", 32'(RegSrc), 1);
        chk("m_aluctl_br", 32'(ALUControl), 0);
      end
      m_flags = nf; m_k = nk; m_err = n_err;
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [3:0] af, input logic rdy);
    @(posedge clk);
    #1;
    Instr = ins; ALUFlags = af; mem.MemReady = rdy;
    #1;
  endtask

  localparam logic [31:0] NOP  = 32'hEC000000;
  localparam logic [31:0] LDR  = 32'hE5903004;
  localparam logic [31:0] STR  = 32'hE5803004;
  localparam logic [31:0] ADDS = 32'hE2921005;
  localparam logic [31:0] ADD  = 32'hE2821005;
  localparam logic [31:0] BEQ  = 32'h0A000002;

  initial begin : stim
    int st, mw, req, abort_at, rs_bad;
    logic rw;
    reset = 1'b0; Instr = NOP; ALUFlags = 4'h0; mem.MemReady = 1'b0;
    #12;
    chk("reset_stall", 32'(Stall), 0);
    chk("reset_memreq", 32'(mem.MemReq), 0);
    chk("reset_flags", 32'(Flags), 0);
    chk("reset_memerr", 32'(MemErr), 0);
    @(posedge clk); #1 reset = 1'b1;

    drive(ADDS, 4'b0000, 0);
    chk("adds_aluctl", 32'(ALUControl), 0);
    chk("adds_alusrc", 32'(ALUSrc), 1);
    chk("adds_regwrite", 32'(RegWrite), 1);
    drive(NOP, 4'b0000, 0);
    chk("adds_flags", 32'(Flags), 4'b0000);
    drive(ADDS, 4'b1011, 0);
    drive(NOP, 4'b0000, 0);
    chk("adds_flags_nzcv", 32'(Flags), 4'b1011);
    drive(32'hE2111005, 4'b0100, 0);
    drive(NOP, 4'b0000, 0);
    chk("ands_keeps_cv", 32'(Flags), 4'b0111);

    drive(32'hE1510001, 4'b0100, 0);
    chk("cmp_regwrite", 32'(RegWrite), 0);
    drive(BEQ, 4'b0000, 0);
    chk("cmp_flags", 32'(Flags), 4'b0100);
    chk("beq_taken", 32'(PCSrc), 1);
    drive(ADDS, 4'b0000, 0);
    drive(BEQ, 4'b0000, 0);
    chk("beq_not_taken", 32'(PCSrc), 0);

    drive(32'h05903004, 4'b0000, 0);
    chk("ldreq_fail_memreq", 32'(mem.MemReq), 0);
    chk("ldreq_fail_stall", 32'(Stall), 0);
    drive(32'hF2921005, 4'b1111, 0);
    chk("nv_regwrite", 32'(RegWrite), 0);
    drive(NOP, 4'b0000, 0);
    chk("nv_flags", 32'(Flags), 4'b0000);
    drive(32'hE282F004, 4'b0000, 0);
    chk("add_pc_pcsrc", 32'(PCSrc), 1);

    drive(LDR, 4'b0000, 1);
    chk("ldr0_memreq", 32'(mem.MemReq), 1);
    chk("ldr0_memtoreg", 32'(MemtoReg), 1);
    chk("ldr0_regwrite", 32'(RegWrite), 1);
    chk("ldr0_stall", 32'(Stall), 0);
    drive(ADD, 4'b0000, 0);
    chk("after_ldr0_memreq", 32'(mem.MemReq), 0);

    st = 0; mw = 0; rw = 0; rs_bad = 0;
    for (int i = 0; i < 4; i++) begin
      drive(STR, 4'b0000, i == 3);
      if (Stall) st++;
      if (mem.MemWrite) mw++;
      rw |= RegWrite;
      if (RegSrc != 2'b10) rs_bad++;
    end
    chk("str_stall_cycles", st, 3);
    chk("str_memwrite_cycles", mw, 4);
    chk("str_regwrite", 32'(rw), 0);
    chk("str_regsrc", rs_bad, 0);
    drive(NOP, 4'b0000, 0);
    chk("after_str_memreq", 32'(mem.MemReq), 0);

    for (int i = 1; i <= TO; i++) begin
      drive(LDR, 4'b0000, i == TO);
      if (i == TO) begin
        chk("ready_beats_timeout_rw", 32'(RegWrite), 1);
        chk("ready_beats_timeout_stall", 32'(Stall), 0);
      end
    end
    drive(NOP, 4'b0000, 0);
    chk("ready_beats_timeout_err", 32'(MemErr), 0);

    req = 0; abort_at = 0; rw = 0;
    for (int i = 1; i <= TO; i++) begin
      drive(LDR, 4'b0000, 0);
      if (mem.MemReq) req++;
      if (!mem.MemReq && !Stall && abort_at == 0) abort_at = i;
      rw |= RegWrite;
    end
    chk("timeout_req_cycles", req, TO - 1);
    chk("timeout_abort_cycle", abort_at, TO);
    chk("timeout_regwrite", 32'(rw), 0);
    drive(NOP, 4'b0000, 0);
    chk("timeout_memerr", 32'(MemErr), 1);
    drive(LDR, 4'b0000, 1);
    chk("timeout_memerr_sticky", 32'(MemErr), 1);

    drive(ADDS, 4'b1111, 0);
    drive(LDR, 4'b0000, 0);
    chk("rstwait_c1_stall", 32'(Stall), 1);
    drive(LDR, 4'b0000, 0);
    chk("rstwait_c2_stall", 32'(Stall), 1);
    reset = 1'b0;
    #1;
    chk("rstwait_stall", 32'(Stall), 0);
    chk("rstwait_memreq", 32'(mem.MemReq), 0);
    chk("rstwait_flags", 32'(Flags), 0);
    chk("rstwait_memerr", 32'(MemErr), 0);
    drive(ADD, 4'b0000, 0);
    reset = 1'b1;
    #1;
    chk("rstwait_exec_memreq", 32'(mem.MemReq), 0);
    chk("rstwait_exec_regwrite", 32'(RegWrite), 1);
    drive(LDR, 4'b0000, 0);
    chk("rstwait_new_stall", 32'(Stall), 1);
    drive(LDR, 4'b0000, 1);
    drive(NOP, 4'b0000, 0);
    drive(NOP, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum number of MemReady wait cycles before a memory access is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Instr, input, 32 bits: the current instruction; the top holds it stable while Stall=1.
REQ-005 SHALL have port ALUFlags, input, 4 bits: {Negative, Zero, Carry, Overflow} from the datapath ALU.
REQ-006 SHALL have port MemReady, input, 1 bit: data memory completes the access this cycle.
REQ-007 SHALL have the following datapath control outputs, widths as named: RegSrc[1:0], ImmSrc[1:0], ALUControl[1:0], RegWrite, ALUSrc, MemtoReg, PCSrc.
REQ-008 SHALL have the following memory outputs, 1 bit each: MemReq (access request) and MemWrite (store qualifier).
REQ-009 SHALL have the following status outputs: Stall, 1 bit (hold PC/Instr); MemErr, 1 bit (sticky timeout); Flags[3:0] (registered NZCV).

Function
REQ-010 SHALL decode the instruction fields as follows: cond=Instr[31:28], Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12].
REQ-011 SHALL decode Op=00 (data processing) as follows:
- ALUSrc=Funct[5]; ImmSrc=00; RegSrc=00.
- Command mapping: ADD(0100)->ALUControl 00; SUB(0010)->01; AND(0000)->10; ORR(1100)->11; CMP(1010)->01 with RegWrite=0.
- Any other command: no writes.
REQ-012 SHALL decode Op=01 (memory) as follows:
- Common: ALUSrc=1; ImmSrc=01; ALUControl=00 if U(Funct[3])=1, else 01.
- LDR (Funct[0]=1): RegSrc=00; MemtoReg=1; RegWrite on completion.
- STR (Funct[0]=0): RegSrc=10; MemWrite=1.
REQ-013 SHALL decode Op=10 (branch) as: ImmSrc=10, ALUSrc=1, RegSrc=01, ALUControl=00, branch=1.
REQ-014 SHALL treat Op=11 as a NOP: RegWrite=MemReq=MemWrite=PCSrc=0.
REQ-015 SHALL compute CondEx from the registered Flags:
- EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE evaluated per ARM definitions.
- AL(1110)=1.
- 1111=0.
REQ-016 SHALL gate every write with CondEx: RegWrite, MemReq, MemWrite, PCSrc, and the flag update.
REQ-017 SHALL drive PCSrc=CondEx & (branch | (RegWrite_decoded & Rd==15)) and SHALL force PCSrc=0 while Stall=1.
REQ-018 SHALL update Flags when S=Funct[0]=1, the instruction is data processing, and CondEx=1:
- NZ are updated for all data-processing commands.
- CV are updated only for ADD, SUB and CMP.
- The update is applied at the clock edge.
REQ-019 SHALL implement a two-state FSM, EXEC and WAIT.
REQ-020 SHALL behave as follows in EXEC for a condition-passing memory instruction:
- MemReq=1.
- If MemReady=1, the access completes in the same cycle: LDR asserts RegWrite, the state stays EXEC, and Stall=0.
- Otherwise Stall=1 and the next state is WAIT with the wait counter set to 1.
REQ-021 SHALL behave as follows in WAIT:
- MemReq=1, MemWrite=store, Stall=1, RegWrite=0, and the counter increments each cycle.
- On MemReady=1: Stall=0, LDR asserts RegWrite that cycle, and the next state is EXEC.
REQ-022 SHALL abort the access when the counter reaches MEM_TIMEOUT without MemReady:
- Abort cycle: MemReq=0, RegWrite=0, Stall=0.
- MemErr set (sticky); next state EXEC.
REQ-023 SHALL give priority to MemReady=1 over timeout when both occur in the same cycle, so the access completes.
REQ-024 SHALL not let a failing condition code enter WAIT; such instructions execute in one cycle with no writes.

Reset
REQ-025 SHALL, while reset=0, asynchronously force:
- FSM to EXEC, counter to 0, Flags to 0000, MemErr to 0.
- RegWrite, MemReq, MemWrite, PCSrc and Stall to 0.
REQ-026 SHALL, on reset asserted in WAIT, abandon the access with no register write and no MemErr.

Structure
REQ-027 SHALL place the following in package control_pkg: the cond code constants, ALUControl encodings, Op encodings, and the FSM state type.
REQ-028 SHALL place the condition evaluation in sub-module cond_logic (inputs cond and Flags; output CondEx).

Verification
REQ-029 SHALL verify flag setting: Instr=E2921005 (ADDS R1,R2,#5) with ALUFlags=0000 -> ALUControl=00, ALUSrc=1, RegWrite=1; next cycle Flags=0000.
REQ-030 SHALL verify compare then branch: CMP E1510001 with ALUFlags=0100 -> RegWrite=0, Flags=0100; then 0A000002 (BEQ) -> PCSrc=1; with Flags=0000 the same BEQ -> PCSrc=0.
REQ-031 SHALL verify a zero-wait load: E5903004 (LDR) with MemReady=1 -> MemReq=1, MemtoReg=1, RegWrite=1, Stall=0, in one cycle.
REQ-032 SHALL verify a waited store: E5803004 (STR) with MemReady low for 3 cycles -> Stall=1 for 3 cycles, MemWrite=1 for 4 cycles, RegSrc=10, RegWrite=0 throughout.
REQ-033 SHALL verify timeout: LDR with MemReady=0 for 15 cycles -> abort at cycle 15, MemErr=1 until reset, RegWrite never 1.
REQ-034 SHALL verify reset mid-wait: reset=0 during WAIT cycle 2 -> Stall=0, MemReq=0, Flags=0000 immediately; FSM in EXEC after release.
